// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and a future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clk_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-source handshake and line-side status of the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 data_bit;
    logic                 busy;
    logic                 done;

    modport master (
        output data, valid,
        input  ready, data_bit, busy, done
    );

    modport slave (
        input  data, valid,
        output ready, data_bit, busy, done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..clk_per_bit-1 and flags the terminal count.
module uart_baud_gen #(
    parameter int clock_frequency = 100000000,
    parameter int baud_rate       = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CPB = uart_pkg::clk_per_bit(clock_frequency, baud_rate);
    localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [TW-1:0] TERMINAL = TW'(CPB - 1);

    if (CPB < 2) begin : g_bad_rate
        $error("uart_baud_gen: clock_frequency/baud_rate must be at least 2");
    end

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tick_o = (count_q == TERMINAL);

    always_comb begin
        count_d = count_q + TW'(1);
        if (clear_i || tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a word on valid/ready and sends start, data (LSB first),
// optional parity and stop bits on a registered line output.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int clock_frequency = 100000000,
    parameter int baud_rate       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_frame_if.slave  bus
);
    localparam int CPB = clk_per_bit(clock_frequency, baud_rate);
    localparam int IW  = $clog2(DATA_BITS + 1);

    if (CPB < 2) begin : g_bad_rate
        $error("uart_tx_frame: clock_frequency/baud_rate must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 parity_d;
    logic [IW-1:0]        idx_q;
    logic                 data_bit_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tick;

    // Timer is held at zero while idle so the start bit gets a full period from accept.
    uart_baud_gen #(
        .clock_frequency (clock_frequency),
        .baud_rate       (baud_rate)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    always_comb begin
        parity_d = 1'b0;
        if (PARITY == PARITY_ODD) begin
            parity_d = ~^bus.data;
        end else if (PARITY == PARITY_EVEN) begin
            parity_d = ^bus.data;
        end
    end

    // The PARITY parameter shadows the imported state name, hence the scoped reference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            idx_q      <= '0;
            data_bit_q <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    data_bit_q <= 1'b1;
                    if (bus.valid && ready_q) begin
                        shift_q    <= bus.data;
                        parity_q   <= parity_d;
                        idx_q      <= '0;
                        data_bit_q <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        data_bit_q <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        idx_q      <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx_q == IW'(DATA_BITS - 1)) begin
                            idx_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                data_bit_q <= parity_q;
                                state_q    <= uart_pkg::PARITY;
                            end else begin
                                data_bit_q <= 1'b1;
                                state_q    <= STOP;
                            end
                        end else begin
                            data_bit_q <= shift_q[0];
                            shift_q    <= shift_q >> 1;
                            idx_q      <= idx_q + IW'(1);
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        data_bit_q <= 1'b1;
                        idx_q      <= '0;
                        state_q    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (idx_q == IW'(STOP_BITS - 1)) begin
                            idx_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    data_bit_q <= 1'b1;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.data_bit = data_bit_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
